// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory bus arbiter.
package mem_arb_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 14;
  localparam int BRAM_ADDR_W = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick; bit 0 of the request vector is port A, bit 1 port B.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int HOST_PRIORITY = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_port
);

  // A single requester always wins; a tie goes to A under host priority, else to the port not served last
  always_comb begin
    o_valid = |i_req;
    o_port  = PORT_A;
    if (i_req == 2'b10) begin
      o_port = PORT_B;
    end else if (i_req == 2'b11 && HOST_PRIORITY == 0 && i_last == PORT_A) begin
      o_port = PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single BRAM/SPRAM bus between the host (port A) and the fabric (port B),
// one transaction at a time with a req/ack handshake per port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_SELECT_BITS = 5,
  parameter int RD_LAT          = 1,
  parameter int HOST_PRIORITY   = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       a_req,
  input  logic                       a_we,
  input  logic                       a_spram,
  input  logic [MEM_SELECT_BITS-1:0] a_sel,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_wdata,
  output logic                       a_ack,
  output logic [DATA_W-1:0]          a_rdata,
  input  logic                       b_req,
  input  logic                       b_we,
  input  logic                       b_spram,
  input  logic [MEM_SELECT_BITS-1:0] b_sel,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_wdata,
  output logic                       b_ack,
  output logic [DATA_W-1:0]          b_rdata,
  input  logic [DATA_W-1:0]          mem_out,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [BRAM_ADDR_W-1:0]     mem_addr,
  output logic [ADDR_W-1:0]          sp_addr,
  output logic [DATA_W-1:0]          mem_in,
  output logic                       rd_en,
  output logic                       wr_en,
  output logic                       bram_or_spram,
  output logic                       busy
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_gnt;
  logic                       r_last;
  logic                       r_we;
  logic                       r_spram;
  logic [MEM_SELECT_BITS-1:0] r_sel;
  logic [ADDR_W-1:0]          r_addr;
  logic [DATA_W-1:0]          r_wdata;
  logic [DATA_W-1:0]          r_a_rdata;
  logic [DATA_W-1:0]          r_b_rdata;
  logic [2:0]                 r_cnt;
  logic                       w_pick_vld;
  logic                       w_pick_port;
  logic                       w_grant;
  logic                       w_rd_last;

  rr_pick2 #(
    .HOST_PRIORITY(HOST_PRIORITY)
  ) u_pick (
    .i_req  ({b_req, a_req}),
    .i_last (r_last),
    .o_valid(w_pick_vld),
    .o_port (w_pick_port)
  );

  assign w_grant   = (r_state == IDLE) && w_pick_vld;
  assign w_rd_last = (r_state == WAIT) && (r_cnt == 3'd0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, one-cycle strobe in ISSUE and one-cycle ack in DONE
  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = ISSUE;
      ISSUE: begin
        wr_en       = r_we;
        rd_en       = !r_we;
        w_state_nxt = r_we ? DONE : WAIT;
      end
      WAIT:    if (r_cnt == 3'd0) w_state_nxt = DONE;
      DONE: begin
        a_ack       = (r_gnt == PORT_A);
        b_ack       = (r_gnt == PORT_B);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winning port's transaction; these registers also drive the bus and hold in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt   <= PORT_A;
      r_we    <= 1'b0;
      r_spram <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_gnt   <= w_pick_port;
      r_we    <= (w_pick_port == PORT_B) ? b_we    : a_we;
      r_spram <= (w_pick_port == PORT_B) ? b_spram : a_spram;
      r_sel   <= (w_pick_port == PORT_B) ? b_sel   : a_sel;
      r_addr  <= (w_pick_port == PORT_B) ? b_addr  : a_addr;
      r_wdata <= (w_pick_port == PORT_B) ? b_wdata : a_wdata;
    end
  end

  // Last-grant pointer starts at B so that A wins the first tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_last <= PORT_B;
    else if (r_state == DONE)  r_last <= r_gnt;
  end

  // Read-latency countdown, loaded as the read strobe goes out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            r_cnt <= 3'd0;
    else if (r_state == ISSUE && !r_we)     r_cnt <= CNT_INIT;
    else if (r_state == WAIT && r_cnt != 0) r_cnt <= r_cnt - 3'd1;
  end

  // Per-port read data, updated only when that port's read completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (w_rd_last) begin
      if (r_gnt == PORT_A) r_a_rdata <= mem_out;
      else                 r_b_rdata <= mem_out;
    end
  end

  assign mem_select    = r_sel;
  assign mem_addr      = r_addr[BRAM_ADDR_W-1:0];
  assign sp_addr       = r_addr;
  assign mem_in        = r_wdata;
  assign bram_or_spram = r_spram;
  assign a_rdata       = r_a_rdata;
  assign b_rdata       = r_b_rdata;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin with RD_LAT=1, host priority with RD_LAT=3)
// driven by directed and random transactions and compared with a cycle-level reference model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic        spram;
    logic [4:0]  sel;
    logic [13:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] mem_out;

  logic        a_req [2];
  logic        a_we [2];
  logic        a_spram [2];
  logic [4:0]  a_sel [2];
  logic [13:0] a_addr [2];
  logic [15:0] a_wdata [2];
  logic        a_ack [2];
  logic [15:0] a_rdata [2];
  logic        b_req [2];
  logic        b_we [2];
  logic        b_spram [2];
  logic [4:0]  b_sel [2];
  logic [13:0] b_addr [2];
  logic [15:0] b_wdata [2];
  logic        b_ack [2];
  logic [15:0] b_rdata [2];
  logic [4:0]  mem_select [2];
  logic [7:0]  mem_addr [2];
  logic [13:0] sp_addr [2];
  logic [15:0] mem_in [2];
  logic        rd_en [2];
  logic        wr_en [2];
  logic        bram_or_spram [2];
  logic        busy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_SELECT_BITS(5),
      .RD_LAT         ((g == 0) ? 1 : 3),
      .HOST_PRIORITY  (g)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .a_req        (a_req[g]),
      .a_we         (a_we[g]),
      .a_spram      (a_spram[g]),
      .a_sel        (a_sel[g]),
      .a_addr       (a_addr[g]),
      .a_wdata      (a_wdata[g]),
      .a_ack        (a_ack[g]),
      .a_rdata      (a_rdata[g]),
      .b_req        (b_req[g]),
      .b_we         (b_we[g]),
      .b_spram      (b_spram[g]),
      .b_sel        (b_sel[g]),
      .b_addr       (b_addr[g]),
      .b_wdata      (b_wdata[g]),
      .b_ack        (b_ack[g]),
      .b_rdata      (b_rdata[g]),
      .mem_out      (mem_out),
      .mem_select   (mem_select[g]),
      .mem_addr     (mem_addr[g]),
      .sp_addr      (sp_addr[g]),
      .mem_in       (mem_in[g]),
      .rd_en        (rd_en[g]),
      .wr_en        (wr_en[g]),
      .bram_or_spram(bram_or_spram[g]),
      .busy         (busy[g])
    );
  end

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [15:0] hist [256];
  int          n_chk = 0;
  int          n_err = 0;

  // Reference model state per instance
  int          model_last [2];
  txn_t        lt [2];
  logic [15:0] mrd [2][2];
  txn_t        qa[$];
  txn_t        qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns fresh random data every cycle; history lets the model look up any past cycle
  initial begin
    mem_out = 16'h0;
    forever begin
      @(negedge clk);
      mem_out = 16'($urandom);
      hist[cyc & 255] = mem_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Grant rule: lone requester wins; on a tie the host wins under priority, else the one not served last
  function automatic int pick(input int k, input bit ra, input bit rb);
    if (ra && rb) return (k == 1) ? 0 : ((model_last[k] == 0) ? 1 : 0);
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom);
    t.spram = 1'($urandom);
    t.sel   = 5'($urandom);
    t.addr  = 14'($urandom);
    t.wdata = 16'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_last[k] = 1;
      lt[k]         = '0;
      mrd[k][0]     = 16'h0;
      mrd[k][1]     = 16'h0;
    end
  endtask

  task automatic present(input int k, input int p, input txn_t t);
    if (p == 0) begin
      a_req[k] = 1'b1; a_we[k] = t.we; a_spram[k] = t.spram;
      a_sel[k] = t.sel; a_addr[k] = t.addr; a_wdata[k] = t.wdata;
    end else begin
      b_req[k] = 1'b1; b_we[k] = t.we; b_spram[k] = t.spram;
      b_sel[k] = t.sel; b_addr[k] = t.addr; b_wdata[k] = t.wdata;
    end
  endtask

  task automatic drop(input int k, input int p);
    if (p == 0) a_req[k] = 1'b0;
    else        b_req[k] = 1'b0;
  endtask

  task automatic chk_bus(input int k);
    chk("mem_select", mem_select[k], lt[k].sel);
    chk("mem_addr", mem_addr[k], lt[k].addr[7:0]);
    chk("sp_addr", sp_addr[k], lt[k].addr);
    chk("mem_in", mem_in[k], lt[k].wdata);
    chk("bram_or_spram", bram_or_spram[k], lt[k].spram);
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy", busy[k], 0);
    chk("rst_rd_en", rd_en[k], 0);
    chk("rst_wr_en", wr_en[k], 0);
    chk("rst_a_ack", a_ack[k], 0);
    chk("rst_b_ack", b_ack[k], 0);
    chk("rst_a_rdata", a_rdata[k], 0);
    chk("rst_b_rdata", b_rdata[k], 0);
    chk("rst_mem_select", mem_select[k], 0);
    chk("rst_sp_addr", sp_addr[k], 0);
    chk("rst_mem_in", mem_in[k], 0);
    chk("rst_bram_or_spram", bram_or_spram[k], 0);
  endtask

  // Serve everything queued in qa/qb on instance k, checking every cycle against the model
  task automatic run_batch(input int k, output int n_ack);
    txn_t cur [2];
    bit   act [2];
    int   pred, exp_stb, exp_ack, stb_cyc, budget;
    n_ack  = 0;
    act[0] = 1'b0;
    act[1] = 1'b0;
    @(negedge clk);
    if (qa.size() > 0) begin cur[0] = qa.pop_front(); act[0] = 1'b1; present(k, 0, cur[0]); end
    if (qb.size() > 0) begin cur[1] = qb.pop_front(); act[1] = 1'b1; present(k, 1, cur[1]); end
    pred    = pick(k, act[0], act[1]);
    exp_stb = cyc + 1;
    exp_ack = -1;
    stb_cyc = -1;
    budget  = 0;
    while ((act[0] || act[1]) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (cyc == exp_stb) begin
        lt[k]   = cur[pred];
        stb_cyc = cyc;
        exp_ack = cyc + 1 + (cur[pred].we ? 0 : lat_of(k));
      end
      chk("wr_en", wr_en[k], (cyc == stb_cyc) && cur[pred].we);
      chk("rd_en", rd_en[k], (cyc == stb_cyc) && !cur[pred].we);
      chk("busy", busy[k], (stb_cyc >= 0) && (cyc >= stb_cyc) && (cyc <= exp_ack));
      chk_bus(k);
      if (cyc == exp_ack && !cur[pred].we)
        mrd[k][pred] = hist[(stb_cyc + lat_of(k)) & 255];
      chk("a_ack", a_ack[k], (cyc == exp_ack) && (pred == 0));
      chk("b_ack", b_ack[k], (cyc == exp_ack) && (pred == 1));
      chk("a_rdata", a_rdata[k], mrd[k][0]);
      chk("b_rdata", b_rdata[k], mrd[k][1]);
      if (cyc == exp_ack) begin
        n_ack++;
        model_last[k] = pred;
        if (pred == 0) begin
          if (qa.size() > 0) begin cur[0] = qa.pop_front(); present(k, 0, cur[0]); end
          else begin act[0] = 1'b0; drop(k, 0); end
        end else begin
          if (qb.size() > 0) begin cur[1] = qb.pop_front(); present(k, 1, cur[1]); end
          else begin act[1] = 1'b0; drop(k, 1); end
        end
        pred    = pick(k, act[0], act[1]);
        exp_stb = cyc + 2;
        exp_ack = -1;
        stb_cyc = -1;
      end
    end
    chk("batch_timeout", budget < 200, 1);
    drop(k, 0);
    drop(k, 1);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    txn_t t;
    int   n, na, nb;
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      present(k, 0, '0); present(k, 1, '0);
      drop(k, 0); drop(k, 1);
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk_zero(k);
    resetn = 1'b1;

    // Host write to BRAM bank 3
    t = '{we: 1'b1, spram: 1'b0, sel: 5'd3, addr: 14'h2A, wdata: 16'hBEEF};
    qa.push_back(t);
    run_batch(0, n);
    chk("acks_host_write", n, 1);

    // Fabric SPRAM read
    t = '{we: 1'b0, spram: 1'b1, sel: 5'd0, addr: 14'h1234, wdata: 16'h0};
    qb.push_back(t);
    run_batch(0, n);
    chk("acks_fabric_read", n, 1);

    // Both ports hold four writes each, round-robin
    for (int i = 0; i < 4; i++) begin
      t = rand_txn(); t.we = 1'b1; qa.push_back(t);
      t = rand_txn(); t.we = 1'b1; qb.push_back(t);
    end
    run_batch(0, n);
    chk("acks_rr", n, 8);

    // Same contention with host priority
    for (int i = 0; i < 4; i++) begin
      t = rand_txn(); t.we = 1'b1; qa.push_back(t);
      t = rand_txn(); t.we = 1'b1; qb.push_back(t);
    end
    run_batch(1, n);
    chk("acks_hp", n, 8);

    // Host read with three-cycle memory latency
    t = rand_txn(); t.we = 1'b0;
    qa.push_back(t);
    run_batch(1, n);
    chk("acks_lat3_read", n, 1);

    // Reset pulsed while the read is waiting for memory
    @(negedge clk);
    t = rand_txn(); t.we = 1'b0;
    present(1, 0, t);
    @(negedge clk);
    chk("pre_rst_rd_en", rd_en[1], 1);
    @(negedge clk);
    chk("pre_rst_busy", busy[1], 1);
    resetn = 1'b0;
    #1;
    chk_zero(1);
    drop(1, 0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_a_ack", a_ack[1], 0);
      chk("rst_hold_busy", busy[1], 0);
    end
    resetn = 1'b1;
    t = rand_txn();
    qa.push_back(t);
    run_batch(1, n);
    chk("acks_after_reset", n, 1);

    // Random mixed traffic on both instances
    for (int r = 0; r < 12; r++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      for (int i = 0; i < na; i++) qa.push_back(rand_txn());
      for (int i = 0; i < nb; i++) qb.push_back(rand_txn());
      run_batch(r % 2, n);
      chk("acks_random", n, na + nb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
